app_mem_responder: RTL and testbench

Synthesizable, BRAM-backed responder for the 29-bit-address / 64-bit-data memory application interface that our DDR3 controller FSM drives. It replaces the DDR3 memory-controller side of that interface on FPGA builds without external DDR, and serves as a cycle-accurate target in simulation. It accepts read/write commands and write data independently, executes them strictly in order against an internal array, and returns read data after a fixed latency.

---
 rtl/app_mem_responder_if.sv | 27 ++
 rtl/app_mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_app_mem_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/app_mem_responder_if.sv
// Memory application interface between a DDR3-style controller FSM (master)
// and a memory target (slave): command channel, write-data channel, read return.
interface app_mem_responder_if;
    logic [28:0] app_addr;
    logic [2:0]  app_cmd;
    logic        app_en;
    logic        app_rdy;
    logic [63:0] app_wdf_data;
    logic [7:0]  app_wdf_mask;
    logic        app_wdf_wren;
    logic        app_wdf_rdy;
    logic        app_wdf_end;
    logic [63:0] app_rd_data;
    logic        app_rd_data_valid;

    // Handshake: a command (app_en/app_rdy) or write-data beat (app_wdf_wren/app_wdf_rdy)
    // transfers on a clk edge where valid and ready are both high; ready never depends on valid.
    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren,
        input  app_rdy, app_wdf_rdy, app_wdf_end, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren,
        output app_rdy, app_wdf_rdy, app_wdf_end, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/app_mem_responder.sv
// BRAM-backed in-order responder for the 29-bit-address / 64-bit-data memory
// application interface: queued commands and write data, fixed-latency reads.
module app_mem_responder #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int RD_LATENCY     = 4,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int WDF_FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    app_mem_responder_if.slave app,
    output logic               dbg_state
);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CP_W   = $clog2(CMD_FIFO_DEPTH);
    localparam int CCNT_W = CP_W + 1;
    localparam int WP_W   = $clog2(WDF_FIFO_DEPTH);
    localparam int WCNT_W = WP_W + 1;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        EXEC       = 1'b0,
        WAIT_WDATA = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic wdf_push, wdf_pop, wdf_full, wdf_empty;
    logic rd_issue, wr_commit;

    // ---------------- command FIFO: {cmd, addr} ----------------
    logic [31:0]       cmd_mem [CMD_FIFO_DEPTH];
    logic [CP_W-1:0]   cmd_wp, cmd_rp;
    logic [CCNT_W-1:0] cmd_cnt;
    logic [2:0]        head_cmd;
    logic [28:0]       head_addr;
    logic [IDX_W-1:0]  head_idx;
    logic              addr_unused;

    assign cmd_full    = (cmd_cnt == CCNT_W'(CMD_FIFO_DEPTH));
    assign cmd_empty   = (cmd_cnt == '0);
    assign app.app_rdy = !rst && !cmd_full;
    assign cmd_push    = app.app_en && app.app_rdy;

    assign {head_cmd, head_addr} = cmd_mem[cmd_rp];
    // Byte offset and bits above the array size are ignored, so addresses alias.
    assign head_idx    = head_addr[3 +: IDX_W];
    assign addr_unused = ^head_addr;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wp] <= {app.app_cmd, app.app_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wp <= cmd_wp + CP_W'(1);
            end
            if (cmd_pop) begin
                cmd_rp <= cmd_rp + CP_W'(1);
            end
            cmd_cnt <= cmd_cnt + CCNT_W'(cmd_push) - CCNT_W'(cmd_pop);
        end
    end

    // ---------------- write-data FIFO: {mask, data} ----------------
    logic [71:0]       wdf_mem [WDF_FIFO_DEPTH];
    logic [WP_W-1:0]   wdf_wp, wdf_rp;
    logic [WCNT_W-1:0] wdf_cnt;
    logic [63:0]       wdf_head_data;
    logic [7:0]        wdf_head_mask;

    assign wdf_full        = (wdf_cnt == WCNT_W'(WDF_FIFO_DEPTH));
    assign wdf_empty       = (wdf_cnt == '0);
    assign app.app_wdf_rdy = !rst && !wdf_full;
    assign wdf_push        = app.app_wdf_wren && app.app_wdf_rdy;

    assign {wdf_head_mask, wdf_head_data} = wdf_mem[wdf_rp];

    always_ff @(posedge clk) begin
        if (wdf_push) begin
            wdf_mem[wdf_wp] <= {app.app_wdf_mask, app.app_wdf_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdf_wp  <= '0;
            wdf_rp  <= '0;
            wdf_cnt <= '0;
        end else begin
            if (wdf_push) begin
                wdf_wp <= wdf_wp + WP_W'(1);
            end
            if (wdf_pop) begin
                wdf_rp <= wdf_rp + WP_W'(1);
            end
            wdf_cnt <= wdf_cnt + WCNT_W'(wdf_push) - WCNT_W'(wdf_pop);
        end
    end

    // ---------------- execute FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EXEC;
        end else begin
            state_q <= state_d;
        end
    end

    // Nothing issues while rst is high, so queued work is discarded, not executed.
    always_comb begin
        state_d   = state_q;
        cmd_pop   = 1'b0;
        wdf_pop   = 1'b0;
        rd_issue  = 1'b0;
        wr_commit = 1'b0;
        if (!rst) begin
            unique case (state_q)
                EXEC: begin
                    if (!cmd_empty) begin
                        if (head_cmd == CMD_READ) begin
                            cmd_pop  = 1'b1;
                            rd_issue = 1'b1;
                        end else if (head_cmd == CMD_WRITE) begin
                            if (!wdf_empty) begin
                                cmd_pop   = 1'b1;
                                wdf_pop   = 1'b1;
                                wr_commit = 1'b1;
                            end else begin
                                state_d = WAIT_WDATA;
                            end
                        end else begin
                            cmd_pop = 1'b1;
                        end
                    end
                end
                WAIT_WDATA: begin
                    if (!wdf_empty) begin
                        cmd_pop   = 1'b1;
                        wdf_pop   = 1'b1;
                        wr_commit = 1'b1;
                        state_d   = EXEC;
                    end
                end
                default: state_d = EXEC;
            endcase
        end
    end

    assign dbg_state = state_q;

    // ---------------- storage array ----------------
    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (!wdf_head_mask[b]) begin
                    mem[head_idx][8*b +: 8] <= wdf_head_data[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 is the array output register; each later stage only loads when a
    // token enters it, so the last stage holds its data until the next valid.
    logic [63:0]           pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_issue;
            if (rd_issue) begin
                pipe_data[0] <= mem[head_idx];
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign app.app_rd_data       = pipe_data[RD_LATENCY-1];
    assign app.app_rd_data_valid = pipe_vld[RD_LATENCY-1];

    logic wdf_end_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdf_end_q <= 1'b0;
        end else begin
            wdf_end_q <= wr_commit;
        end
    end

    assign app.app_wdf_end = wdf_end_q;
endmodule

// File: tb/tb_app_mem_responder.sv
// Directed bench for app_mem_responder: vector table for back-to-back traffic,
// hand-written sequences for stall, backpressure, alias and reset corners.
module tb_app_mem_responder;
    localparam int L   = 4;
    localparam int DW  = 1024;
    localparam int CFD = 4;
    localparam logic [2:0] WR  = 3'b000;
    localparam logic [2:0] RD  = 3'b001;
    localparam logic [2:0] ILL = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];
    int valid_cnt      = 0;
    int end_cnt        = 0;
    int last_valid_cyc = -1;
    int last_end_cyc   = -1;

    typedef struct {
        logic [2:0]  cmd;
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [14];

    app_mem_responder_if bus();

    app_mem_responder #(
        .DEPTH_WORDS(DW),
        .RD_LATENCY(L),
        .CMD_FIFO_DEPTH(CFD),
        .WDF_FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .app(bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    function automatic void check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (bus.app_rd_data_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got valid with data 0x%h, expected no read (cycle %0d)",
                         bus.app_rd_data, cyc);
            end else begin
                check64("rd_data", bus.app_rd_data, exp_q.pop_front());
            end
        end
        if (bus.app_wdf_end === 1'b1) begin
            end_cnt++;
            last_end_cyc = cyc;
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic idle(input int n);
        bus.app_en       = 1'b0;
        bus.app_wdf_wren = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic [2:0] cmd, input logic [28:0] addr,
                         input logic wren, input logic [63:0] data, input logic [7:0] mask);
        bus.app_en       = en;
        bus.app_cmd      = cmd;
        bus.app_addr     = addr;
        bus.app_wdf_wren = wren;
        bus.app_wdf_data = data;
        bus.app_wdf_mask = mask;
        @(negedge clk);
        bus.app_en       = 1'b0;
        bus.app_wdf_wren = 1'b0;
    endtask

    task automatic report();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin : watchdog
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
        report();
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin : test
        int d;
        int m;
        int v0;
        int e0;

        bus.app_en       = 1'b0;
        bus.app_cmd      = '0;
        bus.app_addr     = '0;
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_data = '0;
        bus.app_wdf_mask = '0;

        // cmd, addr, data, mask, expected read data
        vecs[0]  = '{WR,  29'h100, 64'h0123456789ABCDEF, 8'h00, 64'h0};
        vecs[1]  = '{RD,  29'h100, 64'h0,                8'h00, 64'h0123456789ABCDEF};
        vecs[2]  = '{WR,  29'h100, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0};
        vecs[3]  = '{RD,  29'h100, 64'h0,                8'h00, 64'h0123456789ABCDEF};
        vecs[4]  = '{WR,  29'h100, 64'h0000000000000000, 8'hAA, 64'h0};
        vecs[5]  = '{RD,  29'h100, 64'h0,                8'h00, 64'h010045008900CD00};
        vecs[6]  = '{WR,  29'h108, 64'h55AA55AA12345678, 8'h00, 64'h0};
        vecs[7]  = '{WR,  29'h110, 64'h0F0F0F0F0F0F0F0F, 8'h00, 64'h0};
        vecs[8]  = '{RD,  29'h108, 64'h0,                8'h00, 64'h55AA55AA12345678};
        vecs[9]  = '{RD,  29'h110, 64'h0,                8'h00, 64'h0F0F0F0F0F0F0F0F};
        vecs[10] = '{ILL, 29'h100, 64'h0,                8'h00, 64'h0};
        vecs[11] = '{RD,  29'h100, 64'h0,                8'h00, 64'h010045008900CD00};
        vecs[12] = '{WR,  29'h10F, 64'h1111111111111111, 8'hF0, 64'h0};
        vecs[13] = '{RD,  29'h108, 64'h0,                8'h00, 64'h55AA55AA11111111};

        // Reset held for 3 cycles
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("rst_app_rdy", bus.app_rdy, 1'b0);
        check_bit("rst_wdf_rdy", bus.app_wdf_rdy, 1'b0);
        check64("rst_rd_data", bus.app_rd_data, 64'h0);
        check_bit("rst_rd_valid", bus.app_rd_data_valid, 1'b0);
        check_bit("rst_wdf_end", bus.app_wdf_end, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_bit("post_rst_app_rdy", bus.app_rdy, 1'b1);
        check_bit("post_rst_wdf_rdy", bus.app_wdf_rdy, 1'b1);
        check_bit("post_rst_state", dbg_state, 1'b0);

        // Full write with data in the same cycle, read next cycle
        d = cyc;
        drive(1'b1, WR, 29'h40, 1'b1, 64'h1122334455667788, 8'h00);
        exp_q.push_back(64'h1122334455667788);
        drive(1'b1, RD, 29'h40, 1'b0, 64'h0, 8'h00);
        idle(L + 3);
        check_int("wr_end_cycle", last_end_cyc, d + 2);
        check_int("rd_valid_cycle", last_valid_cyc, d + 2 + L);

        // Masked write over the same word
        drive(1'b1, WR, 29'h40, 1'b1, 64'hAAAAAAAA00000000, 8'h0F);
        exp_q.push_back(64'hAAAAAAAA55667788);
        drive(1'b1, RD, 29'h40, 1'b0, 64'h0, 8'h00);
        idle(L + 3);

        // Back-to-back vector table
        for (int i = 0; i < 14; i++) begin
            check_bit("table_app_rdy", bus.app_rdy, 1'b1);
            if (vecs[i].cmd == RD) begin
                exp_q.push_back(vecs[i].exp);
            end
            drive(1'b1, vecs[i].cmd, vecs[i].addr, vecs[i].cmd == WR, vecs[i].data, vecs[i].mask);
        end
        idle(L + 4);

        // Late write data stalls the write and the younger read
        v0 = valid_cnt;
        e0 = end_cnt;
        drive(1'b1, WR, 29'h80, 1'b0, 64'h0, 8'h00);
        exp_q.push_back(64'hDEADBEEFCAFEF00D);
        drive(1'b1, RD, 29'h80, 1'b0, 64'h0, 8'h00);
        idle(10);
        check_int("late_no_valid", valid_cnt, v0);
        check_int("late_no_end", end_cnt, e0);
        check_bit("late_state_wait", dbg_state, 1'b1);
        m = cyc;
        drive(1'b0, WR, 29'h0, 1'b1, 64'hDEADBEEFCAFEF00D, 8'h00);
        idle(L + 4);
        check_int("late_end_count", end_cnt, e0 + 1);
        check_int("late_end_cycle", last_end_cyc, m + 2);
        check_int("late_valid_count", valid_cnt, v0 + 1);
        check_int("late_valid_cycle", last_valid_cyc, m + 2 + L);
        check_bit("late_state_exec", dbg_state, 1'b0);

        // Surplus write data waits until a write command claims it
        e0 = end_cnt;
        drive(1'b0, WR, 29'h0, 1'b1, 64'h3030303030303030, 8'h00);
        idle(4);
        check_int("surplus_no_end", end_cnt, e0);
        drive(1'b1, WR, 29'h300, 1'b0, 64'h0, 8'h00);
        exp_q.push_back(64'h3030303030303030);
        drive(1'b1, RD, 29'h300, 1'b0, 64'h0, 8'h00);
        idle(L + 3);
        check_int("surplus_end", end_cnt, e0 + 1);

        // Backpressure: fill the command queue with data-less writes
        e0 = end_cnt;
        for (int i = 0; i < CFD; i++) begin
            check_bit("bp_rdy_filling", bus.app_rdy, 1'b1);
            drive(1'b1, WR, 29'h200 + 29'(8 * i), 1'b0, 64'h0, 8'h00);
        end
        check_bit("bp_full", bus.app_rdy, 1'b0);
        // Refused while full: this read must never produce a valid
        drive(1'b1, RD, 29'h200, 1'b0, 64'h0, 8'h00);
        check_bit("bp_still_full", bus.app_rdy, 1'b0);
        for (int i = 0; i < CFD; i++) begin
            check_bit("bp_wdf_rdy", bus.app_wdf_rdy, 1'b1);
            drive(1'b0, WR, 29'h0, 1'b1, 64'hB0B0000000000000 | 64'(i), 8'h00);
        end
        idle(6);
        check_bit("bp_rdy_again", bus.app_rdy, 1'b1);
        check_int("bp_end_count", end_cnt, e0 + CFD);
        for (int i = 0; i < CFD; i++) begin
            exp_q.push_back(64'hB0B0000000000000 | 64'(i));
            drive(1'b1, RD, 29'h200 + 29'(8 * i), 1'b0, 64'h0, 8'h00);
        end

        // Address alias: one array-size above 0x40 lands on the same word
        drive(1'b1, WR, 29'h40 + 29'(DW * 8), 1'b1, 64'h0BADF00D12345678, 8'h00);
        exp_q.push_back(64'h0BADF00D12345678);
        drive(1'b1, RD, 29'h40, 1'b0, 64'h0, 8'h00);
        idle(L + 4);

        // Reset while a read is in flight
        v0 = valid_cnt;
        drive(1'b1, RD, 29'h40, 1'b0, 64'h0, 8'h00);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        check64("midrst_rd_data", bus.app_rd_data, 64'h0);
        check_bit("midrst_app_rdy", bus.app_rdy, 1'b0);
        rst = 1'b0;
        idle(2 * L);
        check_int("midrst_no_valid", valid_cnt, v0);

        // Array contents survive reset
        exp_q.push_back(64'h0BADF00D12345678);
        drive(1'b1, RD, 29'h40, 1'b0, 64'h0, 8'h00);
        idle(L + 3);

        check_int("exp_q_drained", exp_q.size(), 0);
        report();
        $finish;
    end
endmodule
